// File: rtl/ff_delay_line.sv
// ff_delay_line: WIDTH-bit word plus valid bit carried through DEPTH posedge
// stages with clock enable, synchronous flush, asynchronous clear and preset.
// A registered occupancy count tracks how many stages currently hold valid=1.
// Optional negedge output stage is built when FF_NEG_STAGE_EN is defined.
module ff_delay_line #(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [WIDTH-1:0]  PRESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         clr_ff2,
  input  logic                         pre_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [WIDTH*DEPTH-1:0]       tap,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic [WIDTH-1:0]             q_neg,
  output logic                         q_neg_valid
);

  localparam int unsigned FillW = $clog2(DEPTH + 1);

  // Stage 0 is the newest word; packing puts stage k at [k*WIDTH +: WIDTH].
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [FillW-1:0]            fill_q, fill_d;

  // Next-state: flush clears valids only; en shifts data and valids together.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    if (flush) begin
      valid_d = '0;
      fill_d  = '0;
    end else if (en) begin
      data_d[0]  = d;
      valid_d[0] = d_valid;
      for (int k = 1; k < int'(DEPTH); k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // Shift-in and shift-out on the same edge keep the count within 0..DEPTH.
      fill_d = fill_q + FillW'(d_valid) - FillW'(valid_q[DEPTH-1]);
    end
  end

  // Stage registers: clear beats preset, preset beats the clocked update.
  always_ff @(posedge clk or posedge clr_ff2 or negedge pre_n) begin
    if (clr_ff2) begin
      data_q  <= '0;
      valid_q <= '0;
      fill_q  <= '0;
    end else if (!pre_n) begin
      data_q  <= {DEPTH{PRESET_VAL}};
      valid_q <= '1;
      fill_q  <= FillW'(DEPTH);
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
    end
  end

  // Output taps come straight from the stage registers.
  always_comb begin
    q       = data_q[DEPTH-1];
    q_valid = valid_q[DEPTH-1];
    tap     = data_q;
    fill    = fill_q;
  end

`ifdef FF_NEG_STAGE_EN
  logic [WIDTH-1:0] q_neg_q;
  logic             q_neg_valid_q;

  // Half-cycle retimed copy of the last stage; ignores en/flush, obeys clear.
  always_ff @(negedge clk or posedge clr_ff2) begin
    if (clr_ff2) begin
      q_neg_q       <= '0;
      q_neg_valid_q <= 1'b0;
    end else begin
      q_neg_q       <= data_q[DEPTH-1];
      q_neg_valid_q <= valid_q[DEPTH-1];
    end
  end

  // Drive the negedge copy out.
  always_comb begin
    q_neg       = q_neg_q;
    q_neg_valid = q_neg_valid_q;
  end
`else
  // No negedge stage built; outputs tied low.
  always_comb begin
    q_neg       = '0;
    q_neg_valid = 1'b0;
  end
`endif

endmodule
